// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder_pkg
//  Purpose  : Shared widths, address map constants and a decode helper for
//             the memory responder.
//  Contents : ADDR_W / DATA_W   - controller bus widths
//             IO_BIT            - address bit selecting the IO space
//             UART_TX_ADDR      - IO write target feeding the UART TX FIFO
//             CYCLE_CNT_ADDR    - base of the 4-byte cycle counter window
//  Revision : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 8;

    localparam int                IO_BIT         = 17;
    localparam logic [ADDR_W-1:0] UART_TX_ADDR   = 18'h30000;
    localparam logic [ADDR_W-1:0] CYCLE_CNT_ADDR = 18'h30004;

    typedef enum logic {
        ACC_READ  = 1'b0,
        ACC_WRITE = 1'b1
    } access_e;

    // True for any of the four byte lanes of the cycle counter.
    function automatic logic is_cycle_cnt_addr(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:2] == CYCLE_CNT_ADDR[ADDR_W-1:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tx_fifo
//  Purpose  : Synchronous FIFO buffering bytes for the UART transmitter.
//  Ports    : clk, rst_n      - clock, async active-low reset
//             push, din      - enqueue request and data
//             pop            - dequeue request (ignored when empty)
//             dout           - head entry, 0 while empty
//             full, empty    - occupancy flags
//             count          - number of stored entries
//  Notes    : A push while full is accepted only if a pop happens on the
//             same edge (the pop frees the slot first).
//  Revision : 1.0 - initial release
// ============================================================================
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign count     = r_count;
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];

    // Storage needs no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Byte-wide memory responder: RAM, memory-mapped UART TX FIFO and
//             a free-running 32-bit cycle counter behind one access port.
//  Ports    : clk, rst_n              - clock, async active-low reset
//             rdy                     - global enable (low freezes state)
//             signal_from_ctrl        - 0 read, 1 write
//             addr_from_ctrl          - byte address, bit 17 selects IO
//             data_from_ctrl          - write byte
//             data_to_ctrl            - registered read byte
//             uart_full_signal        - registered backpressure
//             tx_data, tx_valid       - FIFO head to the UART transmitter
//             tx_ready                - transmitter accepts the head byte
//             overflow_err            - sticky: a UART write was dropped
//  Revision : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int RAM_ADDR_BITS = 17,
    parameter int TX_DEPTH      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              signal_from_ctrl,
    input  logic [ADDR_W-1:0] addr_from_ctrl,
    input  logic [DATA_W-1:0] data_from_ctrl,
    output logic [DATA_W-1:0] data_to_ctrl,
    output logic              uart_full_signal,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              overflow_err
);

    localparam int CNT_W = $clog2(TX_DEPTH) + 1;

    logic [DATA_W-1:0]        r_mem [2**RAM_ADDR_BITS];
    logic [DATA_W-1:0]        r_data_to_ctrl;
    logic                     r_uart_full;
    logic                     r_overflow;
    logic [31:0]              r_cycle_cnt;

    logic                     w_is_io;
    logic                     w_is_write;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_push_ok;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [CNT_W-1:0]         w_fifo_count;
    logic [CNT_W-1:0]         w_next_count;
    logic [RAM_ADDR_BITS-1:0] w_ram_idx;
    logic [DATA_W-1:0]        w_rd_byte;

    assign w_is_io    = addr_from_ctrl[IO_BIT];
    assign w_is_write = (signal_from_ctrl == ACC_WRITE);
    assign w_ram_idx  = addr_from_ctrl[RAM_ADDR_BITS-1:0];

    // FIFO handshakes are qualified by rdy so a frozen cycle changes nothing.
    assign w_push    = rdy & w_is_write & (addr_from_ctrl == UART_TX_ADDR);
    assign w_pop     = rdy & tx_valid & tx_ready;
    assign w_push_ok = w_push & (~w_fifo_full | w_pop);

    // Occupancy after this edge; used to raise backpressure one entry early
    // so the write already in flight from the controller still fits.
    assign w_next_count = w_fifo_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);

    assign tx_valid         = ~w_fifo_empty;
    assign data_to_ctrl     = r_data_to_ctrl;
    assign uart_full_signal = r_uart_full;
    assign overflow_err     = r_overflow;

    tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (DATA_W)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (data_from_ctrl),
        .dout  (tx_data),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (rdy && w_is_write && !w_is_io) begin
            r_mem[w_ram_idx] <= data_from_ctrl;
        end
    end

    always_comb begin
        w_rd_byte = '0;
        if (!w_is_io) begin
            w_rd_byte = r_mem[w_ram_idx];
        end else if (is_cycle_cnt_addr(addr_from_ctrl)) begin
            case (addr_from_ctrl[1:0])
                2'd0:    w_rd_byte = r_cycle_cnt[7:0];
                2'd1:    w_rd_byte = r_cycle_cnt[15:8];
                2'd2:    w_rd_byte = r_cycle_cnt[23:16];
                default: w_rd_byte = r_cycle_cnt[31:24];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_to_ctrl <= '0;
            r_uart_full    <= 1'b0;
            r_overflow     <= 1'b0;
            r_cycle_cnt    <= '0;
        end else if (rdy) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            r_uart_full <= (w_next_count >= CNT_W'(TX_DEPTH - 1));
            if (!w_is_write) begin
                r_data_to_ctrl <= w_rd_byte;
            end
            if (w_push && w_fifo_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Self-checking bench for mem_responder: directed scenarios with
//             literal expectations plus randomized traffic compared every
//             cycle against a queue/array based behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b0;
    logic        signal_from_ctrl = 1'b0;
    logic [17:0] addr_from_ctrl = '0;
    logic [7:0]  data_from_ctrl = '0;
    logic [7:0]  data_to_ctrl;
    logic        uart_full_signal;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        overflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_responder #(
        .RAM_ADDR_BITS (17),
        .TX_DEPTH      (DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rdy              (rdy),
        .signal_from_ctrl (signal_from_ctrl),
        .addr_from_ctrl   (addr_from_ctrl),
        .data_from_ctrl   (data_from_ctrl),
        .data_to_ctrl     (data_to_ctrl),
        .uart_full_signal (uart_full_signal),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .overflow_err     (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: RAM as an associative array, FIFO as a queue,
    // counter as a plain integer.
    // ------------------------------------------------------------------
    logic [7:0]  m_ram [int unsigned];
    logic [7:0]  m_q [$];
    int unsigned m_cnt = 0;
    logic [7:0]  m_data = 8'h00;
    bit          m_data_known = 1'b1;
    bit          m_full = 1'b0;
    bit          m_ovf = 1'b0;
    int unsigned m_a;
    bit          m_do_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_cnt        = 0;
            m_data       = 8'h00;
            m_data_known = 1'b1;
            m_full       = 1'b0;
            m_ovf        = 1'b0;
        end else if (rdy) begin
            m_a      = int'(addr_from_ctrl);
            m_do_pop = tx_ready && (m_q.size() > 0);
            if (!signal_from_ctrl) begin
                if (m_a < 32'h20000) begin
                    if (m_ram.exists(m_a)) begin
                        m_data       = m_ram[m_a];
                        m_data_known = 1'b1;
                    end else begin
                        m_data_known = 1'b0;
                    end
                end else if (m_a >= 32'h30004 && m_a <= 32'h30007) begin
                    m_data       = 8'((m_cnt >> (8 * (m_a - 32'h30004))) & 32'hFF);
                    m_data_known = 1'b1;
                end else begin
                    m_data       = 8'h00;
                    m_data_known = 1'b1;
                end
            end
            if (m_do_pop) void'(m_q.pop_front());
            if (signal_from_ctrl) begin
                if (m_a < 32'h20000) begin
                    m_ram[m_a] = data_from_ctrl;
                end else if (m_a == 32'h30000) begin
                    if (m_q.size() < DEPTH) m_q.push_back(data_from_ctrl);
                    else                    m_ovf = 1'b1;
                end
            end
            m_full = (m_q.size() >= DEPTH - 1);
            m_cnt  = m_cnt + 1;
        end
    end

    // Cycle-by-cycle comparison, sampled mid-period.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("tx_valid", 32'(tx_valid), 32'(m_q.size() > 0));
            chk("tx_data", 32'(tx_data), 32'((m_q.size() > 0) ? m_q[0] : 8'h00));
            chk("uart_full_signal", 32'(uart_full_signal), 32'(m_full));
            chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
            if (m_data_known) chk("data_to_ctrl", 32'(data_to_ctrl), 32'(m_data));
        end
    end

    // One access per call: inputs applied mid-cycle, returns at the next
    // drive slot so outputs reflect the edge that sampled this access.
    task automatic acc(input logic r, input logic wr, input logic [17:0] a,
                       input logic [7:0] d, input logic txr);
        rdy              = r;
        signal_from_ctrl = wr;
        addr_from_ctrl   = a;
        data_from_ctrl   = d;
        tx_ready         = txr;
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rdy      = 1'b0;
        tx_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic rand_phase(input int n, input int txr_one_in);
        int unsigned ram_pool [6] = '{32'h0, 32'h10, 32'h11, 32'h1FFFF, 32'h12345, 32'h0FFFF};
        int unsigned io_pool  [10] = '{32'h30000, 32'h30000, 32'h30000, 32'h30004, 32'h30005,
                                       32'h30006, 32'h30007, 32'h30008, 32'h20000, 32'h3FFFF};
        int unsigned a;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) < 4) a = ram_pool[$urandom_range(0, 5)];
            else                          a = io_pool[$urandom_range(0, 9)];
            acc(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 18'(a),
                8'($urandom_range(0, 255)), 1'($urandom_range(0, txr_one_in - 1) == 0));
        end
    endtask

    int         n_deliv;
    logic [7:0] last_deliv;

    initial begin
        @(negedge clk);
        #2;
        do_reset();

        // Reset state
        chk("rst data_to_ctrl", 32'(data_to_ctrl), 32'h00);
        chk("rst tx_valid", 32'(tx_valid), 32'h0);
        chk("rst tx_data", 32'(tx_data), 32'h00);
        chk("rst uart_full", 32'(uart_full_signal), 32'h0);
        chk("rst overflow", 32'(overflow_err), 32'h0);

        // RAM write then read back
        acc(1, 1, 18'h00010, 8'hA5, 0);
        chk("ram wr holds data_to_ctrl", 32'(data_to_ctrl), 32'h00);
        acc(1, 0, 18'h00010, 8'h00, 0);
        chk("ram rd 0x10", 32'(data_to_ctrl), 32'hA5);
        acc(1, 1, 18'h1FFFF, 8'h3C, 0);
        acc(1, 0, 18'h1FFFF, 8'h00, 0);
        chk("ram rd top", 32'(data_to_ctrl), 32'h3C);
        acc(1, 0, 18'h20000, 8'h00, 0);
        chk("io rd unmapped", 32'(data_to_ctrl), 32'h00);
        // Initialise the random-phase RAM pool
        acc(1, 1, 18'h00000, 8'h11, 0);
        acc(1, 1, 18'h00011, 8'h22, 0);
        acc(1, 1, 18'h12345, 8'h33, 0);
        acc(1, 1, 18'h0FFFF, 8'h44, 0);

        // Cycle counter
        do_reset();
        for (int i = 0; i < 32'h105; i++) acc(1, 0, 18'h20000, 8'h00, 0);
        acc(1, 0, 18'h30004, 8'h00, 0);
        chk("cnt byte0", 32'(data_to_ctrl), 32'h05);
        acc(1, 0, 18'h30005, 8'h00, 0);
        chk("cnt byte1", 32'(data_to_ctrl), 32'h01);
        for (int i = 0; i < 10; i++) acc(0, 0, 18'h30004, 8'h00, 0);
        chk("rdy0 holds data", 32'(data_to_ctrl), 32'h01);
        acc(1, 0, 18'h30004, 8'h00, 0);
        chk("cnt frozen", 32'(data_to_ctrl), 32'h07);

        // Fill with tx_ready low: backpressure and overflow
        do_reset();
        for (int i = 0; i < 9; i++) begin
            acc(1, 1, 18'h30000, 8'(8'h41 + i), 0);
            if (i == 5) chk("full after 6", 32'(uart_full_signal), 32'h0);
            if (i == 6) chk("full after 7", 32'(uart_full_signal), 32'h1);
            if (i == 7) chk("ovf after 8", 32'(overflow_err), 32'h0);
            if (i == 8) chk("ovf after 9", 32'(overflow_err), 32'h1);
        end
        acc(0, 1, 18'h30000, 8'h99, 1);
        chk("rdy0 no pop", 32'(tx_data), 32'h41);

        // In-order delivery of three bytes
        do_reset();
        acc(1, 1, 18'h30000, 8'h41, 0);
        acc(1, 1, 18'h30000, 8'h42, 0);
        acc(1, 1, 18'h30000, 8'h43, 0);
        chk("head 0x41", 32'(tx_data), 32'h41);
        acc(1, 0, 18'h20000, 8'h00, 1);
        chk("head 0x42", 32'(tx_data), 32'h42);
        acc(1, 0, 18'h20000, 8'h00, 1);
        chk("head 0x43", 32'(tx_data), 32'h43);
        acc(1, 0, 18'h20000, 8'h00, 1);
        chk("drained", 32'(tx_valid), 32'h0);

        // Push into a full FIFO while popping
        do_reset();
        for (int i = 0; i < 8; i++) acc(1, 1, 18'h30000, 8'(8'h60 + i), 0);
        acc(1, 1, 18'h30000, 8'h55, 1);
        chk("full push+pop ovf", 32'(overflow_err), 32'h0);
        chk("full push+pop full", 32'(uart_full_signal), 32'h1);
        n_deliv    = 0;
        last_deliv = 8'h00;
        for (int i = 0; i < 12; i++) begin
            if (tx_valid) begin
                n_deliv++;
                last_deliv = tx_data;
            end
            acc(1, 0, 18'h20000, 8'h00, 1);
        end
        chk("deliveries", 32'(n_deliv), 32'd8);
        chk("last delivered", 32'(last_deliv), 32'h55);

        // Reset with data in the FIFO
        do_reset();
        for (int i = 0; i < 4; i++) acc(1, 1, 18'h30000, 8'(8'h70 + i), 0);
        chk("4 held valid", 32'(tx_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async tx_valid", 32'(tx_valid), 32'h0);
        chk("async tx_data", 32'(tx_data), 32'h00);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        acc(1, 0, 18'h20000, 8'h00, 0);
        chk("post rst valid", 32'(tx_valid), 32'h0);
        chk("post rst full", 32'(uart_full_signal), 32'h0);

        // Randomized traffic against the model
        do_reset();
        rand_phase(1500, 2);
        do_reset();
        rand_phase(1500, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
